// File: rtl/uart_frame_assembler_pkg.sv
// Shared definitions for the UART command-frame assembler: FSM encoding,
// default frame geometry and the clock-derived inter-byte gap timeout.
package uart_frame_assembler_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_STALL   = 2'd2
  } asm_state_t;

  localparam int unsigned DEFAULT_FRAME_BYTES = 18;

  // 10 ms gap limit at the 103.34 MHz system clock
  localparam int unsigned CLK_FREQ_HZ            = 103_340_000;
  localparam int unsigned GAP_PER_SECOND         = 100;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = CLK_FREQ_HZ / GAP_PER_SECOND;

  localparam int unsigned GAP_CNT_W = 24;

endpackage

// File: rtl/frame_gap_timer.sv
// 24-bit clear/enable gap counter; tc flags that the next enabled cycle
// would reach TERMINAL, so the owner can react in that same cycle.
module frame_gap_timer
  import uart_frame_assembler_pkg::*;
#(
  parameter int unsigned TERMINAL = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [GAP_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == GAP_CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles fixed-length UART command frames byte-by-byte into lanes,
// checks the end character and hands frames to a valid/ready consumer.
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int unsigned FRAME_BYTES    = DEFAULT_FRAME_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     frame_err,
  output logic                     timeout_err,
  output logic [7:0]               drop_count,
  output logic                     busy
);

  localparam int unsigned W        = 8 * FRAME_BYTES;
  localparam logic [5:0]  LAST_IDX = 6'(FRAME_BYTES - 1);

  asm_state_t     state, state_nxt;
  logic [5:0]     byte_cnt;
  logic [W-1:0]   asm_q, asm_nxt;
  logic           gap_tc, gap_clr, gap_en;
  logic           last_byte, end_match, slot_free;
  logic           wr_en, load_frame, err_set, to_set, drop;

  assign last_byte = (byte_cnt == LAST_IDX);
  assign end_match = (rx_data == asm_q[7:0]);
  assign slot_free = !frame_valid || frame_ready;

  frame_gap_timer #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (gap_clr),
    .en    (gap_en),
    .tc    (gap_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (rx_valid) state_nxt = S_COLLECT;
      S_COLLECT:
        if (rx_valid) begin
          if (last_byte)
            state_nxt = (end_match && !slot_free) ? S_STALL : S_IDLE;
        end else if (gap_tc) begin
          state_nxt = S_IDLE;
        end
      S_STALL:
        if (slot_free) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    load_frame = 1'b0;
    err_set    = 1'b0;
    to_set     = 1'b0;
    drop       = 1'b0;
    gap_en     = 1'b0;
    gap_clr    = 1'b1;
    unique case (state)
      S_IDLE:
        wr_en = rx_valid;
      S_COLLECT: begin
        wr_en      = rx_valid;
        load_frame = rx_valid && last_byte && end_match && slot_free;
        err_set    = rx_valid && last_byte && !end_match;
        to_set     = !rx_valid && gap_tc;
        gap_en     = !rx_valid;
        gap_clr    = rx_valid;
      end
      S_STALL: begin
        load_frame = slot_free;
        drop       = rx_valid;
      end
      default: ;
    endcase
  end

  // The final byte is merged combinationally so a completing frame can load
  // into frame_data in the same cycle it arrives.
  always_comb begin
    asm_nxt = asm_q;
    if (wr_en)
      asm_nxt[8*byte_cnt +: 8] = rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q       <= '0;
      byte_cnt    <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      asm_q       <= asm_nxt;
      byte_cnt    <= (state_nxt != S_COLLECT) ? '0 :
                     (wr_en ? byte_cnt + 6'd1 : byte_cnt);
      frame_err   <= err_set;
      timeout_err <= to_set;
      if (load_frame) begin
        frame_data  <= asm_nxt;
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler (18-byte frames, 100-cycle gap limit).
module tb_uart_frame_assembler;

  localparam int unsigned FB = 18;
  localparam int unsigned TO = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [8*FB-1:0] frame_data;
  logic            frame_valid;
  logic            frame_ready;
  logic            frame_err;
  logic            timeout_err;
  logic [7:0]      drop_count;
  logic            busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  uart_frame_assembler #(
    .FRAME_BYTES    (FB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] lane(input int unsigned idx);
    return frame_data[8*idx +: 8];
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // byte 0 = first, bytes 1..16 = base + i - 1, byte 17 = last
  task automatic send_range(input logic [7:0] first, input logic [7:0] base,
                            input logic [7:0] last, input int unsigned from, input int unsigned upto);
    for (int unsigned i = from; i <= upto; i++) begin
      if (i == 0)             send_byte(first);
      else if (i == FB - 1)   send_byte(last);
      else                    send_byte(base + 8'(i - 1));
    end
  endtask

  initial begin
    reset       = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    frame_ready = 1'b1;
    tick(2);
    check_eq("rst_valid", 32'(frame_valid), 32'd0);
    check_eq("rst_busy",  32'(busy),        32'd0);
    check_eq("rst_drop",  32'(drop_count),  32'd0);
    check_eq("rst_data",  frame_data[31:0], 32'd0);
    reset = 1'b0;
    tick(1);

    // Basic frame: "B" + 16 x 0x11 + "B"
    send_byte(8'h42);
    check_eq("b_busy", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < 16; i++) send_byte(8'h11);
    send_byte(8'h42);
    check_eq("b_valid",  32'(frame_valid), 32'd1);
    check_eq("b_lane0",  32'(lane(0)),     32'h42);
    check_eq("b_lane1",  32'(lane(1)),     32'h11);
    check_eq("b_lane17", 32'(lane(17)),    32'h42);
    check_eq("b_err",    32'(frame_err),   32'd0);
    check_eq("b_idle",   32'(busy),        32'd0);
    tick(1);
    check_eq("b_consumed", 32'(frame_valid), 32'd0);

    // End-char mismatch: "D" ... "E"
    send_range(8'h44, 8'h01, 8'h45, 0, FB - 1);
    check_eq("e_err",   32'(frame_err),   32'd1);
    check_eq("e_valid", 32'(frame_valid), 32'd0);
    tick(1);
    check_eq("e_pulse", 32'(frame_err),   32'd0);
    send_range(8'h41, 8'h20, 8'h41, 0, FB - 1);
    check_eq("e_next_valid", 32'(frame_valid), 32'd1);
    check_eq("e_next_lane5", 32'(lane(5)),     32'h24);
    tick(1);

    // Gap timeout after 5 bytes
    send_range(8'h43, 8'h90, 8'h43, 0, 4);
    tick(TO - 1);
    check_eq("t_before", 32'(timeout_err), 32'd0);
    check_eq("t_busy",   32'(busy),        32'd1);
    tick(1);
    check_eq("t_pulse",  32'(timeout_err), 32'd1);
    check_eq("t_idle",   32'(busy),        32'd0);
    tick(1);
    check_eq("t_single", 32'(timeout_err), 32'd0);
    send_range(8'h43, 8'h30, 8'h43, 0, FB - 1);
    check_eq("t_next_valid", 32'(frame_valid), 32'd1);
    check_eq("t_next_lane0", 32'(lane(0)),     32'h43);
    check_eq("t_next_lane1", 32'(lane(1)),     32'h30);
    tick(1);

    // Byte arriving on the terminal-count cycle wins
    send_range(8'h58, 8'h60, 8'h58, 0, 2);
    tick(TO - 1);
    send_range(8'h58, 8'h60, 8'h58, 3, 3);
    check_eq("tc_no_to", 32'(timeout_err), 32'd0);
    check_eq("tc_busy",  32'(busy),        32'd1);
    send_range(8'h58, 8'h60, 8'h58, 4, FB - 1);
    check_eq("tc_valid", 32'(frame_valid), 32'd1);
    check_eq("tc_lane3", 32'(lane(3)),     32'h62);
    check_eq("tc_err",   32'(frame_err),   32'd0);
    tick(1);

    // Back-pressure: second frame stalls, extra bytes dropped
    frame_ready = 1'b0;
    send_range(8'h50, 8'h30, 8'h50, 0, FB - 1);
    check_eq("s_first_valid", 32'(frame_valid), 32'd1);
    send_range(8'h51, 8'h50, 8'h51, 0, FB - 1);
    check_eq("s_stall_busy", 32'(busy),     32'd1);
    check_eq("s_held_lane0", 32'(lane(0)),  32'h50);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    check_eq("s_drops",      32'(drop_count), 32'd3);
    check_eq("s_held_lane1", 32'(lane(1)),    32'h30);
    frame_ready = 1'b1;
    tick(1);
    check_eq("s_rel_valid", 32'(frame_valid), 32'd1);
    check_eq("s_rel_lane0", 32'(lane(0)),     32'h51);
    check_eq("s_rel_lane2", 32'(lane(2)),     32'h51);
    check_eq("s_rel_idle",  32'(busy),        32'd0);
    tick(1);
    check_eq("s_drained",   32'(frame_valid), 32'd0);
    check_eq("s_drop_keep", 32'(drop_count),  32'd3);

    // Reset in the middle of a frame
    send_range(8'h52, 8'h10, 8'h52, 0, 8);
    reset = 1'b1;
    #1;
    check_eq("r_busy",  32'(busy),        32'd0);
    check_eq("r_drop",  32'(drop_count),  32'd0);
    check_eq("r_data",  frame_data[31:0], 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check_eq("r_no_err", 32'({frame_err, timeout_err, frame_valid}), 32'd0);
    send_range(8'h53, 8'h70, 8'h53, 0, FB - 1);
    check_eq("r_valid",  32'(frame_valid), 32'd1);
    check_eq("r_lane0",  32'(lane(0)),     32'h53);
    check_eq("r_lane9",  32'(lane(9)),     32'h78);
    check_eq("r_lane17", 32'(lane(17)),    32'h53);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
